// File: rtl/in_feature_loader_if.sv
// Bus bundle between the pixel stream source, the input-feature loader and the
// in_feature dual-port RAM write ports.
interface in_feature_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] address_a;
    logic [ADDR_WIDTH-1:0] address_b;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  wren_a;
    logic                  wren_b;
    logic                  rden_a;
    logic                  rden_b;

    // Stream source side; also observes the RAM port traffic.
    modport master (
        output s_data, s_valid, s_last,
        input  s_ready,
        input  address_a, address_b, data_a, data_b,
        input  wren_a, wren_b, rden_a, rden_b
    );

    // Loader side: consumes the stream and drives the RAM write ports.
    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready,
        output address_a, address_b, data_a, data_b,
        output wren_a, wren_b, rden_a, rden_b
    );
endinterface

// File: rtl/in_feature_loader.sv
// Writer side of the layer-1 input-feature RAM. Packs the pixel stream into
// pair writes on RAM ports a/b, then hands the RAM to the network and holds
// net_enable until the final layer reports done.
//
// state | meaning
// IDLE  | waiting for enable, stream not accepted
// LOAD  | accepting pixels, writing completed pairs one cycle later
// FINAL | even frame: last pair write on the RAM ports, stream closed
// FLUSH | odd frame: lone last pixel written on port a only
// DRAIN | one idle cycle so the last RAM write completes
// RUN   | network owns the RAM, net_enable high until net_done
// DONE  | RAM returned to loader, frame counted, re-arm on enable
module in_feature_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 9,
    parameter int FRAME_WORDS = 400
) (
    input  logic                 clock,
    input  logic                 reset,
    in_feature_loader_if.slave   bus,
    input  logic                 enable,
    input  logic                 net_done,
    output logic                 loader_owns_ram,
    output logic                 net_enable,
    output logic                 frame_error,
    output logic [15:0]          frame_count
);
    // One extra bit so a full 2**ADDR_WIDTH frame still counts without aliasing.
    localparam int               CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_WORDS - 1);
    localparam bit               ODD_FRAME = (FRAME_WORDS % 2) == 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, FINAL, FLUSH, DRAIN, RUN, DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      pix_cnt;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  accept;
    logic                  at_last;

    assign accept     = bus.s_valid && (state == LOAD);
    assign at_last    = (pix_cnt == LAST_IDX);
    assign bus.rden_a = 1'b0;
    assign bus.rden_b = 1'b0;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and state-level outputs.
    always_comb begin
        state_nxt       = state;
        bus.s_ready     = 1'b0;
        net_enable      = 1'b0;
        loader_owns_ram = 1'b1;
        case (state)
            IDLE:  if (enable) state_nxt = LOAD;
            LOAD: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid && at_last) state_nxt = ODD_FRAME ? FLUSH : FINAL;
            end
            FINAL: state_nxt = DRAIN;
            FLUSH: state_nxt = DRAIN;
            DRAIN: state_nxt = RUN;
            RUN: begin
                net_enable      = 1'b1;
                loader_owns_ram = 1'b0;
                if (net_done) state_nxt = DONE;
            end
            DONE:    state_nxt = enable ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pixel counting, pair packing, registered RAM writes, error and frame tracking.
    // The lone odd-frame pixel is written straight from the stream on acceptance,
    // so its write lands in FLUSH with the same value hold_reg captures.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_cnt       <= '0;
            hold_reg      <= '0;
            bus.wren_a    <= 1'b0;
            bus.wren_b    <= 1'b0;
            bus.address_a <= '0;
            bus.address_b <= '0;
            bus.data_a    <= '0;
            bus.data_b    <= '0;
            frame_error   <= 1'b0;
            frame_count   <= '0;
        end else begin
            bus.wren_a <= 1'b0;
            bus.wren_b <= 1'b0;
            if (accept) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
                if (bus.s_last != at_last) frame_error <= 1'b1;
                if (pix_cnt[0]) begin
                    bus.wren_a    <= 1'b1;
                    bus.wren_b    <= 1'b1;
                    bus.address_a <= {pix_cnt[ADDR_WIDTH-1:1], 1'b0};
                    bus.data_a    <= hold_reg;
                    bus.address_b <= pix_cnt[ADDR_WIDTH-1:0];
                    bus.data_b    <= bus.s_data;
                end else begin
                    hold_reg <= bus.s_data;
                    if (at_last) begin
                        bus.wren_a    <= 1'b1;
                        bus.address_a <= pix_cnt[ADDR_WIDTH-1:0];
                        bus.data_a    <= bus.s_data;
                    end
                end
            end
            if (state == RUN && net_done) frame_count <= frame_count + 16'd1;
            if (state == DONE) pix_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_in_feature_loader.sv
// Bench for in_feature_loader: an even (4-pixel) and an odd (5-pixel) frame
// instance share one random stimulus stream; each is compared every cycle
// against a frame-level behavioural model, with a directed opening frame
// pinned by literal expectations.
module tb_in_feature_loader;
    localparam int DW = 16;
    localparam int AW = 9;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          net_done = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last0 = 1'b0;
    logic          s_last1 = 1'b0;

    logic          own0, ne0, fe0, own1, ne1, fe1;
    logic [15:0]   fc0, fc1;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    in_feature_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    in_feature_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    assign bus0.s_data  = s_data;
    assign bus0.s_valid = s_valid;
    assign bus0.s_last  = s_last0;
    assign bus1.s_data  = s_data;
    assign bus1.s_valid = s_valid;
    assign bus1.s_last  = s_last1;

    in_feature_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_WORDS(4)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave), .enable(enable), .net_done(net_done),
        .loader_owns_ram(own0), .net_enable(ne0), .frame_error(fe0), .frame_count(fc0)
    );

    in_feature_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_WORDS(5)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave), .enable(enable), .net_done(net_done),
        .loader_owns_ram(own1), .net_enable(ne1), .frame_error(fe1), .frame_count(fc1)
    );

    // Behavioural model: phase of the frame life cycle, accepted-pixel count,
    // a countdown of closing cycles, and the RAM port values expected now.
    typedef enum int {M_IDLE, M_LOAD, M_TAIL, M_RUN, M_DONE} mphase_t;

    int            fw[2] = '{4, 5};
    mphase_t       ph[2];
    int            cnt[2];
    int            tail[2];
    logic [DW-1:0] hold[2];
    logic [15:0]   fcm[2];
    logic          err[2];
    logic          ewa[2], ewb[2];
    logic [AW-1:0] eaa[2], eab[2];
    logic [DW-1:0] eda[2], edb[2];

    task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s unit%0d got=%h want=%h at %0t", nm, u, act, exp, $time);
        end
    endtask

    task automatic model_step(input int u);
        int   k;
        logic sl;
        sl = (u == 0) ? s_last0 : s_last1;
        if (reset) begin
            ph[u] = M_IDLE; cnt[u] = 0; tail[u] = 0; hold[u] = '0; fcm[u] = '0; err[u] = 1'b0;
            ewa[u] = 1'b0; ewb[u] = 1'b0; eaa[u] = '0; eab[u] = '0; eda[u] = '0; edb[u] = '0;
        end else begin
            ewa[u] = 1'b0;
            ewb[u] = 1'b0;
            case (ph[u])
                M_IDLE: if (enable) ph[u] = M_LOAD;
                M_LOAD: if (s_valid) begin
                    k = cnt[u];
                    if (sl != (k == fw[u] - 1)) err[u] = 1'b1;
                    if (k % 2 == 1) begin
                        ewa[u] = 1'b1; ewb[u] = 1'b1;
                        eaa[u] = AW'(k - 1); eda[u] = hold[u];
                        eab[u] = AW'(k);     edb[u] = s_data;
                    end else begin
                        hold[u] = s_data;
                        if (k == fw[u] - 1) begin
                            ewa[u] = 1'b1; eaa[u] = AW'(k); eda[u] = s_data;
                        end
                    end
                    cnt[u] = cnt[u] + 1;
                    if (k == fw[u] - 1) begin
                        ph[u] = M_TAIL;
                        tail[u] = 2;
                    end
                end
                M_TAIL: begin
                    tail[u] = tail[u] - 1;
                    if (tail[u] == 0) ph[u] = M_RUN;
                end
                M_RUN: if (net_done) begin
                    fcm[u] = fcm[u] + 16'd1;
                    ph[u] = M_DONE;
                end
                M_DONE: begin
                    cnt[u] = 0;
                    ph[u] = enable ? M_LOAD : M_IDLE;
                end
                default: ph[u] = M_IDLE;
            endcase
        end
    endtask

    task automatic chk_unit(input int u, input logic rdy, input logic wa, input logic wb,
                            input logic ra, input logic rb,
                            input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                            input logic [DW-1:0] da, input logic [DW-1:0] db,
                            input logic ne, input logic own, input logic fe, input logic [15:0] fcv);
        chk("s_ready", u, 32'(rdy), 32'(ph[u] == M_LOAD));
        chk("net_enable", u, 32'(ne), 32'(ph[u] == M_RUN));
        chk("owns_ram", u, 32'(own), 32'(ph[u] != M_RUN));
        chk("wren_a", u, 32'(wa), 32'(ewa[u]));
        chk("wren_b", u, 32'(wb), 32'(ewb[u]));
        chk("rden", u, 32'({ra, rb}), 32'(0));
        chk("address_a", u, 32'(aa), 32'(eaa[u]));
        chk("address_b", u, 32'(ab), 32'(eab[u]));
        chk("data_a", u, 32'(da), 32'(eda[u]));
        chk("data_b", u, 32'(db), 32'(edb[u]));
        chk("frame_error", u, 32'(fe), 32'(err[u]));
        chk("frame_count", u, 32'(fcv), 32'(fcm[u]));
    endtask

    // Advance the model on each edge, then compare both instances just after it.
    always @(posedge clock) begin
        for (int u = 0; u < 2; u++) model_step(u);
        #1;
        chk_unit(0, bus0.s_ready, bus0.wren_a, bus0.wren_b, bus0.rden_a, bus0.rden_b,
                 bus0.address_a, bus0.address_b, bus0.data_a, bus0.data_b, ne0, own0, fe0, fc0);
        chk_unit(1, bus1.s_ready, bus1.wren_a, bus1.wren_b, bus1.rden_a, bus1.rden_b,
                 bus1.address_a, bus1.address_b, bus1.data_a, bus1.data_b, ne1, own1, fe1, fc1);
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("lit_reset_owns", 0, 32'(own0), 32'(1));
        chk("lit_reset_outs", 1, 32'({ne1, bus1.s_ready, bus1.wren_a, bus1.wren_b, fe1}), 32'(0));
        chk("lit_reset_count", 1, 32'(fc1), 32'(0));

        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(17 * (i + 1));
            s_last0 = (i == 3);
            s_last1 = (i == 4);
            @(negedge clock);
            if (i == 3) begin
                chk("lit_pair_wren", 0, 32'({bus0.wren_a, bus0.wren_b}), 32'h3);
                chk("lit_pair_addr_a", 0, 32'(bus0.address_a), 32'(2));
                chk("lit_pair_data_a", 0, 32'(bus0.data_a), 32'h33);
                chk("lit_pair_addr_b", 0, 32'(bus0.address_b), 32'(3));
                chk("lit_pair_data_b", 0, 32'(bus0.data_b), 32'h44);
                chk("lit_ready_drop", 0, 32'(bus0.s_ready), 32'(0));
            end
            if (i == 4) begin
                chk("lit_flush_wren", 1, 32'({bus1.wren_a, bus1.wren_b}), 32'h2);
                chk("lit_flush_addr_a", 1, 32'(bus1.address_a), 32'(4));
                chk("lit_flush_data_a", 1, 32'(bus1.data_a), 32'h55);
            end
        end
        s_valid = 1'b0;
        s_last0 = 1'b0;
        s_last1 = 1'b0;
        enable  = 1'b0;
        @(negedge clock);
        chk("lit_net_enable", 0, 32'({ne0, own0}), 32'h2);
        net_done = 1'b1;
        @(negedge clock);
        chk("lit_done_count", 0, 32'(fc0), 32'(1));
        chk("lit_done_owns", 0, 32'({ne0, own0}), 32'h1);
        chk("lit_odd_run", 1, 32'({ne1, fc1}), 32'h10000);
        @(negedge clock);
        chk("lit_odd_count", 1, 32'(fc1), 32'(1));
        chk("lit_idle_ignore", 0, 32'(fc0), 32'(1));
        chk("lit_no_error", 0, 32'({fe0, fe1}), 32'(0));
        net_done = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 3) != 0);
            s_valid  = ($urandom_range(0, 2) != 0);
            s_data   = DW'($urandom);
            net_done = ($urandom_range(0, 9) == 0);
            s_last0  = (cnt[0] == fw[0] - 1) ^ ($urandom_range(0, 49) == 0);
            s_last1  = (cnt[1] == fw[1] - 1) ^ ($urandom_range(0, 49) == 0);
            @(negedge clock);
        end
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
